// File: rtl/sisc_fetch_unit.sv
// sisc_fetch_unit: instruction-side companion to the SISC control FSM.
// Owns PC, IR and status register and runs a req/ack fetch handshake to
// instruction memory. Branch evaluation and status writes are applied here.
// Optional feature macro: IMEM_TIMEOUT_EN abandons a fetch after TIMEOUT
// WAIT cycles without imem_ack (IR <= NOOP, sticky fetch_err).
module sisc_fetch_unit #(
    parameter int PC_W    = 16,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_req,
    input  logic            br_en,
    input  logic            br_rel,
    input  logic            br_neg,
    input  logic            stat_we,
    input  logic [3:0]      stat_in,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    output logic [3:0]      opcode,
    output logic [3:0]      mm,
    output logic [3:0]      rd,
    output logic [3:0]      rs,
    output logic [3:0]      rt,
    output logic [15:0]     imm,
    output logic [3:0]      stat,
    output logic [PC_W-1:0] pc,
    output logic            fetch_done,
    output logic            fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   addr_q, addr_d;
    logic [31:0]       ir_q, ir_d;
    logic [3:0]        stat_q, stat_d;
    logic              req_q, req_d;
    logic              done_q, done_d;
    logic              br_taken;
    logic [PC_W-1:0]   br_target;
    logic              tmo_hit;

`ifdef IMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    // Timeout fires on the last permitted WAIT cycle if memory stays silent.
    always_comb begin
        tmo_hit = (state_q == S_WAIT) && !imem_ack && (cnt_q == TMO_LAST);
        cnt_d   = '0;
        err_d   = err_q | tmo_hit;
        if (state_q == S_WAIT && !imem_ack && !tmo_hit) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Timeout counter and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign fetch_err = err_q;
`else
    assign tmo_hit   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    // Branch condition uses the registered stat, so a same-cycle stat_we
    // has no effect on it; target is absolute imm or PC + sign-extended imm.
    always_comb begin
        if (br_neg) begin
            br_taken = ((stat_q & ir_q[27:24]) == 4'b0000);
        end else begin
            br_taken = ((stat_q & ir_q[27:24]) != 4'b0000);
        end
        if (br_rel) begin
            br_target = pc_q + PC_W'(signed'(ir_q[15:0]));
        end else begin
            br_target = PC_W'(ir_q[15:0]);
        end
    end

    // Next-state logic: fetch FSM, PC/IR/stat updates, registered outputs.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        stat_d  = stat_q;

        case (state_q)
            S_IDLE: begin
                if (fetch_req) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_DONE;
                end else if (tmo_hit) begin
                    ir_d    = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A taken branch overrides the post-fetch increment.
        if (br_en && br_taken) begin
            pc_d = br_target;
        end

        if (stat_we) begin
            stat_d = stat_in;
        end

        // Address is frozen for the whole WAIT phase, otherwise follows PC.
        if (state_q == S_WAIT && state_d == S_WAIT) begin
            addr_d = addr_q;
        end else begin
            addr_d = pc_d;
        end

        req_d  = (state_d == S_WAIT);
        done_d = (state_d == S_DONE);
    end

    // State and architectural registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
            ir_q    <= '0;
            stat_q  <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            stat_q  <= stat_d;
            req_q   <= req_d;
            done_q  <= done_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign fetch_done = done_q;
    assign pc         = pc_q;
    assign stat       = stat_q;
    assign opcode     = ir_q[31:28];
    assign mm         = ir_q[27:24];
    assign rd         = ir_q[23:20];
    assign rs         = ir_q[19:16];
    assign rt         = ir_q[15:12];
    assign imm        = ir_q[15:0];

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Directed bench for sisc_fetch_unit; a scoreboard queue holds the expected
// IR/PC for every fetch and is drained on each fetch_done pulse.
module tb_sisc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req, br_en, br_rel, br_neg, stat_we;
    logic [3:0]  stat_in;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [3:0]  opcode, mm, rd, rs, rt, stat;
    logic [15:0] imm, pc;
    logic        fetch_done, fetch_err;

    always #5 clk = ~clk;

    sisc_fetch_unit #(.PC_W(16), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req),
        .br_en(br_en), .br_rel(br_rel), .br_neg(br_neg),
        .stat_we(stat_we), .stat_in(stat_in),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .opcode(opcode), .mm(mm), .rd(rd), .rs(rs), .rt(rt), .imm(imm),
        .stat(stat), .pc(pc), .fetch_done(fetch_done), .fetch_err(fetch_err)
    );

    typedef struct {
        logic [31:0] ir;
        logic [15:0] pc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Drain one scoreboard entry per fetch_done pulse.
    always @(negedge clk) begin
        if (fetch_done === 1'b1) begin : mon
            exp_t e;
            done_cnt++;
            tests++;
            assert (sb.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_done: got pulse expected none at pc %h", pc);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_ir", {opcode, mm, rd, rs, imm}, e.ir);
                check("sb_rt", {28'd0, rt}, {28'd0, e.ir[15:12]});
                check("sb_pc", {16'd0, pc}, {16'd0, e.pc});
            end
        end
    end

    // Called at a negedge in IDLE; returns at the negedge after DONE.
    task automatic fetch(input logic [31:0] word, input int lat,
                         input logic [15:0] want_addr, input logic [15:0] want_pc,
                         input logic with_br);
        exp_t e;
        e.ir = word;
        e.pc = want_pc;
        sb.push_back(e);
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        check("req_rise", {31'd0, imem_req}, 32'd1);
        check("addr", {16'd0, imem_addr}, {16'd0, want_addr});
        repeat (lat) @(negedge clk);
        check("req_hold", {31'd0, imem_req}, 32'd1);
        check("addr_hold", {16'd0, imem_addr}, {16'd0, want_addr});
        imem_ack  = 1'b1;
        imem_data = word;
        br_en     = with_br;
        @(negedge clk);
        imem_ack  = 1'b0;
        imem_data = 32'h0;
        br_en     = 1'b0;
        check("done_pulse", {31'd0, fetch_done}, 32'd1);
        check("req_drop", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        check("done_low", {31'd0, fetch_done}, 32'd0);
    endtask

    task automatic branch(input logic rel, input logic neg);
        br_en  = 1'b1;
        br_rel = rel;
        br_neg = neg;
        @(negedge clk);
        br_en  = 1'b0;
        br_rel = 1'b0;
        br_neg = 1'b0;
    endtask

    initial begin : stim
        int d0;
        rst = 1'b1; fetch_req = 1'b0; br_en = 1'b0; br_rel = 1'b0; br_neg = 1'b0;
        stat_we = 1'b0; stat_in = 4'h0; imem_ack = 1'b0; imem_data = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_pc", {16'd0, pc}, 32'd0);
        check("rst_ir", {opcode, mm, rd, rs, imm}, 32'd0);
        check("rst_stat", {28'd0, stat}, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_done", {31'd0, fetch_done}, 32'd0);
        check("rst_err", {31'd0, fetch_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic fetch, ack 3 cycles after request.
        d0 = done_cnt;
        fetch(32'h81230000, 3, 16'h0000, 16'h0001, 1'b0);
        check("f1_opcode", {28'd0, opcode}, 32'd8);
        check("f1_mm", {28'd0, mm}, 32'd1);
        check("f1_rd", {28'd0, rd}, 32'd2);
        check("f1_rs", {28'd0, rs}, 32'd3);
        check("f1_pc", {16'd0, pc}, 32'h0001);
        check("f1_one_pulse", done_cnt - d0, 1);

        // Status write then absolute branches.
        stat_we = 1'b1; stat_in = 4'b0001;
        @(negedge clk);
        stat_we = 1'b0;
        check("stat_load", {28'd0, stat}, 32'd1);
        fetch(32'h01000010, 0, 16'h0001, 16'h0002, 1'b0);
        branch(1'b0, 1'b0);
        check("bra_taken", {16'd0, pc}, 32'h0010);
        branch(1'b0, 1'b1);
        check("bne_not_taken", {16'd0, pc}, 32'h0010);

        // Relative branch wrapping below zero.
        fetch(32'h01000001, 1, 16'h0010, 16'h0011, 1'b0);
        branch(1'b0, 1'b0);
        check("bra_to_1", {16'd0, pc}, 32'h0001);
        fetch(32'h0100FFFC, 0, 16'h0001, 16'h0002, 1'b0);
        branch(1'b1, 1'b0);
        check("brr_wrap", {16'd0, pc}, 32'hFFFE);

        // Branch in the same cycle as stat_we sees the old stat (1 -> taken).
        stat_we = 1'b1; stat_in = 4'b0000;
        branch(1'b1, 1'b0);
        stat_we = 1'b0;
        check("old_stat_pc", {16'd0, pc}, 32'hFFFA);
        check("new_stat", {28'd0, stat}, 32'd0);
        stat_we = 1'b1; stat_in = 4'b0001;
        @(negedge clk);
        stat_we = 1'b0;

        // Fetch at 0xFFFF wraps PC to 0.
        fetch(32'h01000004, 0, 16'hFFFA, 16'hFFFB, 1'b0);
        branch(1'b1, 1'b0);
        check("brr_fwd", {16'd0, pc}, 32'hFFFF);
        fetch(32'h0F230040, 2, 16'hFFFF, 16'h0000, 1'b0);
        check("pc_wrap", {16'd0, pc}, 32'h0000);

        // Taken branch colliding with imem_ack.
        fetch(32'h7ABCDEF0, 1, 16'h0000, 16'h0040, 1'b1);
        check("coll_pc", {16'd0, pc}, 32'h0040);
        check("coll_opcode", {28'd0, opcode}, 32'd7);

        // Stray ack while idle changes nothing.
        imem_ack = 1'b1; imem_data = 32'h12345678;
        @(negedge clk);
        imem_ack = 1'b0; imem_data = 32'h0;
        @(negedge clk);
        check("idle_ack_pc", {16'd0, pc}, 32'h0040);
        check("idle_ack_ir", {opcode, mm, rd, rs, imm}, 32'h7ABCDEF0);
`ifndef IMEM_TIMEOUT_EN
        check("err_tied", {31'd0, fetch_err}, 32'd0);
`endif

        // Reset in the middle of WAIT.
        d0 = done_cnt;
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        check("mw_req", {31'd0, imem_req}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mw_req_drop", {31'd0, imem_req}, 32'd0);
        check("mw_pc", {16'd0, pc}, 32'd0);
        check("mw_stat", {28'd0, stat}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        imem_ack = 1'b1; imem_data = 32'hDEADBEEF;
        @(negedge clk);
        imem_ack = 1'b0; imem_data = 32'h0;
        check("late_ack_ir", {opcode, mm, rd, rs, imm}, 32'd0);
        check("late_ack_pc", {16'd0, pc}, 32'd0);
        check("late_ack_done", {31'd0, fetch_done}, 32'd0);
        @(negedge clk);
        check("late_ack_cnt", done_cnt - d0, 0);

        fetch(32'h30000000, 0, 16'h0000, 16'h0001, 1'b0);

`ifdef IMEM_TIMEOUT_EN
        // Timeout: four silent WAIT cycles then DONE with NOOP and sticky error.
        begin : tmo
            int waited;
            exp_t e;
            e.ir = 32'h0;
            e.pc = 16'h0001;
            sb.push_back(e);
            fetch_req = 1'b1;
            @(negedge clk);
            fetch_req = 1'b0;
            waited = 0;
            while (fetch_done !== 1'b1 && waited < 12) begin
                @(negedge clk);
                waited++;
            end
            check("tmo_latency", waited, 4);
            check("tmo_err", {31'd0, fetch_err}, 32'd1);
            check("tmo_opcode", {28'd0, opcode}, 32'd0);
            check("tmo_pc", {16'd0, pc}, 32'h0001);
            @(negedge clk);
            fetch(32'h81230000, 0, 16'h0001, 16'h0002, 1'b0);
            check("err_sticky", {31'd0, fetch_err}, 32'd1);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("err_clear", {31'd0, fetch_err}, 32'd0);
        end
`endif

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
